reg_write_arbiter: RTL and testbench

//  Round-robin arbiter sharing one 32-bit register write port (Data/WE/address) among NREQ requesters.

---
 rtl/reg_write_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : reg_write_arbiter
//  Description : Round-robin arbiter that shares one register-bank write port
//                (WE/WADDR/WDATA) among NREQ requesters. One winner is chosen
//                per clock edge. The winner gets a one-cycle GNT strobe that
//                serves as its write acknowledge.
//
//  Ports
//    CLK       in   1        rising-edge clock
//    RST       in   1        asynchronous reset, active-high
//    REQ       in   NREQ     per-requester write request (level)
//    REQ_ADDR  in   NREQ*AW  requester i address in [i*AW +: AW]
//    REQ_DATA  in   NREQ*DW  requester i data in [i*DW +: DW]
//    LOCK      in   NREQ     per-requester lock request (ARB_LOCK_EN only)
//    GNT       out  NREQ     one-hot write acknowledge, registered pulse
//    WE        out  1        register write enable, registered
//    WADDR     out  AW       register write address, registered
//    WDATA     out  DW       register write data, registered
//    BUSY      out  1        any unmasked request pending (combinational)
//
//  Optional feature macro: ARB_LOCK_EN
//    When this macro is defined, the LOCK port and the LOCKED state are added.
//    A requester that holds LOCK at its grant edge keeps sole ownership.
//    Ownership ends when LOCK drops or when MAX_LOCK grants have been made.
//
//  Revision    : 1.0  initial release
// ============================================================================
module reg_write_arbiter #(
    parameter int NREQ     = 4,
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int MAX_LOCK = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NREQ-1:0]      REQ,
    input  logic [NREQ*AW-1:0]   REQ_ADDR,
    input  logic [NREQ*DW-1:0]   REQ_DATA,
`ifdef ARB_LOCK_EN
    input  logic [NREQ-1:0]      LOCK,
`endif
    output logic [NREQ-1:0]      GNT,
    output logic                 WE,
    output logic [AW-1:0]        WADDR,
    output logic [DW-1:0]        WDATA,
    output logic                 BUSY
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
`ifdef ARB_LOCK_EN
    localparam int c_CNT_W = $clog2(MAX_LOCK + 1);
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t                r_state;
    logic [c_PTR_W-1:0]    r_ptr;
    logic [NREQ-1:0]       r_gnt;
    logic                  r_we;
    logic [AW-1:0]         r_waddr;
    logic [DW-1:0]         r_wdata;
`ifdef ARB_LOCK_EN
    logic [c_CNT_W-1:0]    r_lock_cnt;
`endif

    logic [NREQ-1:0]       w_elig;
    logic                  w_found;
    logic [c_PTR_W-1:0]    w_win;
    logic [c_PTR_W-1:0]    w_win_inc;
    logic [c_PTR_W-1:0]    w_ptr_inc;
    logic [c_PTR_W-1:0]    w_idx;
    logic [NREQ-1:0]       w_gnt_oh;
    logic [AW-1:0]         w_sel_addr;
    logic [DW-1:0]         w_sel_data;

    // ------------------------------------------------------------------------
    // Winner selection. The last winner is masked for one cycle so that a
    // held request is not written twice. While locked, the pointer holds the
    // owner and only the owner may win.
    // ------------------------------------------------------------------------
    always_comb begin
        w_elig = REQ & ~r_gnt;
`ifdef ARB_LOCK_EN
        if (r_state == ST_LOCKED) begin
            w_elig = '0;
            w_elig[r_ptr] = REQ[r_ptr] & ~r_gnt[r_ptr];
        end
`endif
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_idx = c_PTR_W'((int'(r_ptr) + k) % NREQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_win_inc  = (w_win == c_PTR_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
    assign w_ptr_inc  = (r_ptr == c_PTR_W'(NREQ - 1)) ? '0 : r_ptr + 1'b1;
    assign w_sel_addr = REQ_ADDR[w_win*AW +: AW];
    assign w_sel_data = REQ_DATA[w_win*DW +: DW];

    always_comb begin
        w_gnt_oh        = '0;
        w_gnt_oh[w_win] = 1'b1;
    end

    // ------------------------------------------------------------------------
    // State, pointer and registered write port
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= '0;
`ifdef ARB_LOCK_EN
            r_lock_cnt <= '0;
`endif
        end else begin
            case (r_state)
`ifdef ARB_LOCK_EN
                ST_LOCKED: begin
                    // Ownership ends on this edge without a grant. Round-robin
                    // resumes just past the owner on the next edge.
                    if (!LOCK[r_ptr] || (r_lock_cnt == c_CNT_W'(MAX_LOCK))) begin
                        r_state    <= ST_IDLE;
                        r_ptr      <= w_ptr_inc;
                        r_lock_cnt <= '0;
                        r_gnt      <= '0;
                        r_we       <= 1'b0;
                    end else if (w_found) begin
                        r_gnt      <= w_gnt_oh;
                        r_we       <= 1'b1;
                        r_waddr    <= w_sel_addr;
                        r_wdata    <= w_sel_data;
                        r_lock_cnt <= r_lock_cnt + 1'b1;
                    end else begin
                        r_gnt      <= '0;
                        r_we       <= 1'b0;
                    end
                end
`endif
                default: begin
                    if (w_found) begin
                        r_gnt   <= w_gnt_oh;
                        r_we    <= 1'b1;
                        r_waddr <= w_sel_addr;
                        r_wdata <= w_sel_data;
`ifdef ARB_LOCK_EN
                        if (LOCK[w_win]) begin
                            r_state    <= ST_LOCKED;
                            r_ptr      <= w_win;
                            r_lock_cnt <= c_CNT_W'(1);
                        end else begin
                            r_state    <= ST_GRANT;
                            r_ptr      <= w_win_inc;
                        end
`else
                        r_state <= ST_GRANT;
                        r_ptr   <= w_win_inc;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                        r_gnt   <= '0;
                        r_we    <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign GNT   = r_gnt;
    assign WE    = r_we;
    assign WADDR = r_waddr;
    assign WDATA = r_wdata;
    assign BUSY  = |(REQ & ~r_gnt);

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_write_arbiter
//  Description : Self-checking bench for reg_write_arbiter. It compares the
//                DUT against a behavioural round-robin model that uses a
//                pointer, the last winner and the last write values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int NREQ     = 4;
    localparam int DW       = 32;
    localparam int AW       = 5;
    localparam int MAX_LOCK = 3;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic [NREQ-1:0]      REQ = '0;
    logic [NREQ*AW-1:0]   REQ_ADDR;
    logic [NREQ*DW-1:0]   REQ_DATA;
`ifdef ARB_LOCK_EN
    logic [NREQ-1:0]      LOCK = '0;
`endif
    logic [NREQ-1:0]      GNT;
    logic                 WE;
    logic [AW-1:0]        WADDR;
    logic [DW-1:0]        WDATA;
    logic                 BUSY;

    logic [AW-1:0]        t_addr [NREQ];
    logic [DW-1:0]        t_data [NREQ];

    // reference model state
    int                   m_ptr;
    int                   m_prev;
    logic [AW-1:0]        m_waddr;
    logic [DW-1:0]        m_wdata;

    int                   pass_cnt  = 0;
    int                   total_cnt = 0;

    reg_write_arbiter #(
        .NREQ     (NREQ),
        .DW       (DW),
        .AW       (AW),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .REQ_ADDR (REQ_ADDR),
        .REQ_DATA (REQ_DATA),
`ifdef ARB_LOCK_EN
        .LOCK     (LOCK),
`endif
        .GNT      (GNT),
        .WE       (WE),
        .WADDR    (WADDR),
        .WDATA    (WDATA),
        .BUSY     (BUSY)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        REQ_ADDR = '0;
        REQ_DATA = '0;
        for (int i = 0; i < NREQ; i++) begin
            REQ_ADDR[i*AW +: AW] = t_addr[i];
            REQ_DATA[i*DW +: DW] = t_data[i];
        end
    end

    task automatic model_reset();
        m_ptr   = 0;
        m_prev  = -1;
        m_waddr = '0;
        m_wdata = '0;
    endtask

    // One clock edge. The model predicts the result from the inputs that are
    // present at the edge. The task returns after the edge plus 1.
    task automatic step(output logic [NREQ-1:0] eg, output logic ewe);
        int w;
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (w < 0 && REQ[i] && i != m_prev) w = i;
        end
        if (w >= 0) begin
            eg      = NREQ'(1 << w);
            ewe     = 1'b1;
            m_ptr   = (w + 1) % NREQ;
            m_waddr = t_addr[w];
            m_wdata = t_data[w];
        end else begin
            eg  = '0;
            ewe = 1'b0;
        end
        m_prev = w;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ = '0;
`ifdef ARB_LOCK_EN
        LOCK = '0;
`endif
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        logic [NREQ-1:0] eg;
        logic            ewe;
        RST = 1'b1;
        REQ = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            t_addr[i] = AW'(i + 1);
            t_data[i] = 32'hA000_0000 + i;
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge CLK);
            #1;
            total_cnt++;
            if (GNT !== '0 || WE !== 1'b0 || WADDR !== '0 || WDATA !== '0)
                $display("FAIL reset_hold c%0d: GNT=%b WE=%b WADDR=%0d WDATA=%h, required all zero",
                         c, GNT, WE, WADDR, WDATA);
            else pass_cnt++;
        end
        RST = 1'b0;
        model_reset();
        step(eg, ewe);
        total_cnt++;
        if (GNT !== 4'b0001 || eg !== 4'b0001 || WE !== 1'b1 || WDATA !== t_data[0])
            $display("FAIL reset_first: GNT=%b WE=%b WDATA=%h, required GNT=0001 WE=1 WDATA=%h",
                     GNT, WE, WDATA, t_data[0]);
        else pass_cnt++;
    endtask

    task automatic test_single();
        logic [NREQ-1:0] eg;
        logic            ewe;
        do_reset();
        t_addr[2] = 5'd7;
        t_data[2] = 32'hDEADBEEF;
        REQ = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            step(eg, ewe);
            total_cnt++;
            if (GNT !== eg || WE !== ewe || WADDR !== m_waddr || WDATA !== m_wdata ||
                (c % 2 == 0 && (GNT !== 4'b0100 || WADDR !== 5'd7 || WDATA !== 32'hDEADBEEF)) ||
                (c % 2 == 1 && WE !== 1'b0))
                $display("FAIL single c%0d: GNT=%b WE=%b WADDR=%0d WDATA=%h, required GNT=%b WE=%b WADDR=%0d WDATA=%h",
                         c, GNT, WE, WADDR, WDATA, eg, ewe, m_waddr, m_wdata);
            else pass_cnt++;
        end
    endtask

    task automatic test_all_round_robin();
        logic [NREQ-1:0] eg;
        logic            ewe;
        logic [NREQ-1:0] seq [5];
        seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
        seq[3] = 4'b1000; seq[4] = 4'b0001;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            t_addr[i] = AW'(10 + i);
            t_data[i] = 32'h1111_0000 * (i + 1);
        end
        REQ = 4'b1111;
        for (int c = 0; c < 5; c++) begin
            step(eg, ewe);
            total_cnt++;
            if (GNT !== seq[c] || GNT !== eg || WE !== 1'b1 || WDATA !== m_wdata || WADDR !== m_waddr)
                $display("FAIL all_rr c%0d: GNT=%b WE=%b WDATA=%h, required GNT=%b WE=1 WDATA=%h",
                         c, GNT, WE, WDATA, seq[c], m_wdata);
            else pass_cnt++;
        end
    endtask

    task automatic test_wrap_and_drop();
        logic [NREQ-1:0] eg;
        logic            ewe;
        logic [NREQ-1:0] seq [5];
        seq[0] = 4'b0010; seq[1] = 4'b0001; seq[2] = 4'b0010;
        seq[3] = 4'b0000; seq[4] = 4'b0000;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0:       REQ = 4'b0010;        // moves the pointer to 2
                1, 2:    REQ = 4'b0011;
                3: begin
                    REQ = 4'b0001;
                    #3;
                    REQ = 4'b0000;             // dropped before the edge
                end
                default: REQ = 4'b0000;
            endcase
            step(eg, ewe);
            total_cnt++;
            if (GNT !== seq[c] || GNT !== eg || WE !== ewe || WADDR !== m_waddr ||
                WDATA !== m_wdata || BUSY !== |(REQ & ~eg))
                $display("FAIL wrap_drop c%0d: GNT=%b WE=%b WDATA=%h BUSY=%b, required GNT=%b WE=%b WDATA=%h BUSY=%b",
                         c, GNT, WE, WDATA, BUSY, seq[c], ewe, m_wdata, |(REQ & ~eg));
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] eg;
        logic            ewe;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!REQ[i]) begin
                    t_addr[i] = AW'($urandom);
                    t_data[i] = $urandom;
                end
            end
            REQ = NREQ'($urandom);
            step(eg, ewe);
            total_cnt++;
            if (GNT !== eg || WE !== ewe || WADDR !== m_waddr || WDATA !== m_wdata ||
                BUSY !== |(REQ & ~eg))
                $display("FAIL random c%0d: GNT=%b WE=%b WADDR=%0d WDATA=%h BUSY=%b, required GNT=%b WE=%b WADDR=%0d WDATA=%h BUSY=%b",
                         c, GNT, WE, WADDR, WDATA, BUSY, eg, ewe, m_waddr, m_wdata, |(REQ & ~eg));
            else pass_cnt++;
        end
    endtask

    task automatic test_midreset();
        logic [NREQ-1:0] eg;
        logic            ewe;
        do_reset();
        REQ = 4'b1111;
        step(eg, ewe);
        step(eg, ewe);
        #2;
        RST = 1'b1;
        #1;
        total_cnt++;
        if (WE !== 1'b0 || GNT !== '0)
            $display("FAIL midreset_async: WE=%b GNT=%b, required WE=0 GNT=0000", WE, GNT);
        else pass_cnt++;
        @(posedge CLK);
        #1;
        total_cnt++;
        if (WE !== 1'b0 || GNT !== '0 || WADDR !== '0 || WDATA !== '0)
            $display("FAIL midreset_hold: WE=%b GNT=%b WADDR=%0d WDATA=%h, required all zero",
                     WE, GNT, WADDR, WDATA);
        else pass_cnt++;
        RST = 1'b0;
        model_reset();
        step(eg, ewe);
        total_cnt++;
        if (GNT !== eg || GNT !== 4'b0001 || WE !== 1'b1 || WDATA !== m_wdata)
            $display("FAIL midreset_release: GNT=%b WE=%b WDATA=%h, required GNT=0001 WE=1 WDATA=%h",
                     GNT, WE, WDATA, m_wdata);
        else pass_cnt++;
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        logic [NREQ-1:0] seq [7];
        seq[0] = 4'b0010; seq[1] = 4'b0000; seq[2] = 4'b0010; seq[3] = 4'b0000;
        seq[4] = 4'b0010; seq[5] = 4'b0000; seq[6] = 4'b0100;
        do_reset();
        LOCK = 4'b0010;
        REQ  = 4'b0110;
        for (int c = 0; c < 7; c++) begin
            @(posedge CLK);
            #1;
            total_cnt++;
            if (GNT !== seq[c] || WE !== |seq[c] || BUSY !== |(REQ & ~seq[c]))
                $display("FAIL lock c%0d: GNT=%b WE=%b BUSY=%b, required GNT=%b WE=%b BUSY=%b",
                         c, GNT, WE, BUSY, seq[c], |seq[c], |(REQ & ~seq[c]));
            else pass_cnt++;
        end
        LOCK = '0;
        REQ  = '0;
    endtask
`endif

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            t_addr[i] = '0;
            t_data[i] = '0;
        end
        model_reset();
        test_reset();
        test_single();
        test_all_round_robin();
        test_wrap_and_drop();
        test_random();
        test_midreset();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
